// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding, default
//                frame geometry and the even-parity helper used by both the
//                receiver and the transmitter.
//  Contents    : OVERSAMPLE_DEFAULT, DATA_BITS_DEFAULT, rx_state_e,
//                even_parity()
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;  // clk cycles per bit
  localparam int DATA_BITS_DEFAULT  = 8;   // payload bits per frame

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  // Payloads narrower than 32 bits are zero-extended, which leaves the XOR
  // reduction unchanged.
  function automatic logic even_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit.
//  Parameters  : RESET_VAL - value both flops take during reset
//  Ports       : clk   in  destination clock
//                rst_n in  asynchronous active-low reset
//                d     in  asynchronous input
//                q     out synchronized output (two clk of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first, OVERSAMPLE clk per bit.
//                Detects the start bit, samples each data bit at its centre,
//                checks the stop bit and strobes the byte out for one cycle.
//                A low stop bit reports frame_err and waits for the line to
//                return high before listening again.
//  Macro       : UART_RX_PARITY_EN - adds an even-parity bit between data
//                and stop, plus the parity_err output.
//  Parameters  : OVERSAMPLE (even, >= 4), DATA_BITS
//  Ports       : clk           in  oversampling clock
//                rst_n         in  asynchronous active-low reset
//                data_in       in  serial line, asynchronous, idle high
//                data_received out last good byte
//                received      out one-cycle strobe on data_received update
//                frame_err     out one-cycle strobe on low stop bit
//                busy          out high whenever not IDLE
//                parity_err    out (macro only) strobe alongside received
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 received,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e             state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [BIT_W-1:0]      bitn_q,      bitn_d;
  logic [DATA_BITS-1:0]  shift_q,     shift_d;
  logic [DATA_BITS-1:0]  data_q,      data_d;
  logic                  received_q,  received_d;
  logic                  frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit_q,    par_bit_d;
  logic                  parity_err_q, parity_err_d;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitn_q       <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      received_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitn_q       <= bitn_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      received_q   <= received_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bitn_d       = bitn_q;
    shift_d      = shift_q;
    data_d       = data_q;
    received_d   = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      // Re-check the line half a bit in so short glitches are rejected.
      START: begin
        if (cnt_q == c_cnt_half) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bitn_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      // Right shift with entry at the MSB: the first bit lands in bit 0.
      DATA: begin
        if (cnt_q == c_cnt_last) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bitn_d  = bitn_q + 1'b1;
          if (bitn_q == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == c_cnt_last) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end
      end
`endif

      // Leaving at the stop-bit centre gives half a bit of margin to catch
      // a back-to-back start edge.
      STOP: begin
        if (cnt_q == c_cnt_last) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d     = shift_q;
            received_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = even_parity(32'(shift_q)) ^ par_bit_q;
`endif
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      // A held-low line must not be mistaken for a stream of start bits.
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_received = data_q;
  assign received      = received_q;
  assign frame_err     = frame_err_q;
  assign busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err    = parity_err_q;
`endif

endmodule : uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first. Pairs with the existing transmitter on the same 16x-baud clock domain.
- Samples the serial line at OVERSAMPLE ticks per bit and detects the start bit.
- Takes data at each bit centre and checks the stop bit.
- Presents each byte with a one-cycle strobe to the consumer logic.

Parameters:
- OVERSAMPLE, 16, clk cycles per bit; must be even and >= 4.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  input  1  16x-baud clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  1  serial line from pin, asynchronous, idle high.
- data_received  output  DATA_BITS  last good byte; holds until the next good frame.
- received  output  1  one-cycle pulse when data_received updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; counters = 0; shift register = 0.
  - data_received = 0, received = 0, frame_err = 0, busy = 0.
  - Both synchronizer flops reset to 1.
- Input sync: data_in passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Tick counter cnt: width clog2(OVERSAMPLE), cleared on every state entry. Bit counter bitn: width clog2(DATA_BITS+1).
- IDLE:
  - When rx_s == 0 -> START, cnt = 0.
- START:
  - cnt increments. At cnt == OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s == 0 -> DATA, cnt = 0, bitn = 0.
  - rx_s == 1 -> IDLE, no output (glitch rejection).
- DATA:
  - cnt increments and wraps at OVERSAMPLE-1. At cnt == OVERSAMPLE-1, shift rx_s in at the MSB, right shift, so the first received bit ends at bit 0. bitn++.
  - After DATA_BITS samples -> STOP (or PARITY, see Optional Feature), cnt = 0.
- STOP:
  - At cnt == OVERSAMPLE-1, sample rx_s.
  - rx_s == 1 -> data_received <= shift register, received = 1 for one cycle, -> IDLE.
  - rx_s == 0 -> frame_err = 1 for one cycle, data_received unchanged, -> BREAK.
- BREAK:
  - Wait until rx_s == 1, then -> IDLE. This prevents a held-low line or break from retriggering.
- Latency: received rises 2 + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE cycles after the start-bit falling edge at the pin, ±1 for synchronizer phase. Nominal for 16/8: 154.
- Back-to-back frames: IDLE is re-entered at the stop-bit centre, so a start edge half a bit later is caught. No dead time beyond one cycle.
- received and frame_err are never high together; each is high for exactly one cycle per frame.
- Reset mid-frame: the partial byte is discarded, no strobe, and the block restarts in IDLE. A line already low at reset release enters START after sync, and a line still low at the bit centre is taken as a frame.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP. It samples one even-parity bit at cnt == OVERSAMPLE-1.
  - Adds output parity_err (1 bit). It pulses in the same cycle as received, and data_received still updates.
  - Latency grows by OVERSAMPLE.
- Undefined: no PARITY state, no parity_err port, pure 8N1.

Decomposition:
- Package uart_pkg:
  - state encoding typedef: IDLE, START, DATA, PARITY, STOP, BREAK.
  - default OVERSAMPLE and DATA_BITS constants.
  - the shared parity function (also usable by the transmitter).
- Sub-module sync_2ff (2-flop synchronizer, reset value parameter) is natural and reusable. Everything else stays in uart_rx.

Test Plan:
- Single frame 0xA5, 16 clk/bit, line idle high -> received pulses once, data_received = 0xA5, frame_err = 0, latency 154±1.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three received pulses, values in order, no frame_err.
- 4-cycle low glitch on idle line -> START aborts, busy returns 0, no strobe.
- Frame 0x55 with stop bit driven low, then line held low 40 bit times -> one frame_err pulse, data_received keeps its prior value, no new frame until the line returns high; the next frame 0x12 is received correctly.
- rst_n low for 3 cycles during data bit 4 of 0x81 -> all outputs 0 immediately; the following frame 0x7E is received correctly.
- With UART_RX_PARITY_EN: 0x03 with parity 0 -> parity_err = 0; 0x03 with parity 1 -> parity_err pulses with received and data_received = 0x03.
